// File: rtl/div_prescale.sv
// Operand pre-scaler for the Goldschmidt divider: shifts the divisor left until its MSB
// is set, records the shift count, and looks up an 8-bit reciprocal seed.
module div_prescale (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] a_q,
    output logic [7:0] b_n,
    output logic [2:0] shamt,
    output logic [7:0] seed,
    output logic       div0
);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e     state_q, state_d;
    logic [7:0] dividend_q, dividend_d;
    logic [7:0] divisor_q, divisor_d;
    logic [2:0] shamt_q, shamt_d;
    logic [7:0] seed_q, seed_d;
    logic       div0_q, div0_d;

    // Reciprocal of each divisor bin midpoint (8 + i + 0.5) / 16, as unsigned Q1.7.
    function automatic logic [7:0] seed_lut(input logic [2:0] idx);
        logic [7:0] val;
        unique case (idx)
            3'd0:    val = 8'd241;
            3'd1:    val = 8'd216;
            3'd2:    val = 8'd195;
            3'd3:    val = 8'd178;
            3'd4:    val = 8'd164;
            3'd5:    val = 8'd152;
            3'd6:    val = 8'd141;
            default: val = 8'd132;
        endcase
        return val;
    endfunction

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        shamt_d    = shamt_q;
        seed_d     = seed_q;
        div0_d     = div0_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dividend_d = a;
                    divisor_d  = b;
                    shamt_d    = 3'd0;
                    div0_d     = 1'b0;
                    // A zero divisor can never normalise, so skip straight to the result.
                    if (b == 8'd0) begin
                        div0_d  = 1'b1;
                        seed_d  = 8'd0;
                        state_d = StHold;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (divisor_q[7]) begin
                    seed_d  = seed_lut(divisor_q[6:4]);
                    state_d = StHold;
                end else begin
                    divisor_d = {divisor_q[6:0], 1'b0};
                    shamt_d   = shamt_q + 3'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dividend_q <= 8'd0;
            divisor_q  <= 8'd0;
            shamt_q    <= 3'd0;
            seed_q     <= 8'd0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            shamt_q    <= shamt_d;
            seed_q     <= seed_d;
            div0_q     <= div0_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StHold);
    assign a_q       = dividend_q;
    assign b_n       = divisor_q;
    assign shamt     = shamt_q;
    assign seed      = seed_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_div_prescale.sv
// Self-checking bench for div_prescale: directed cases plus randomized operands and
// backpressure, checked against an arithmetic reference model.
module tb_div_prescale;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_q;
    logic [7:0] b_n;
    logic [2:0] shamt;
    logic [7:0] seed;
    logic       div0;

    int total = 0;
    int bad   = 0;

    div_prescale dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_q       (a_q),
        .b_n       (b_n),
        .shamt     (shamt),
        .seed      (seed),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: normalise by repeated doubling; seed = round(128 / bin midpoint).
    // Latency is the number of edges after the accept edge until out_valid is seen.
    function automatic void model(input int bv, output int bn, output int sh, output int sd,
                                  output int d0, output int lat);
        int d;
        bn = bv;
        sh = 0;
        if (bv == 0) begin
            sd  = 0;
            d0  = 1;
            lat = 0;
        end else begin
            while (bn < 128) begin
                bn = bn * 2;
                sh = sh + 1;
            end
            d   = 17 + 2 * ((bn - 128) / 16);
            sd  = (2 * 4096 + d) / (2 * d);
            d0  = 0;
            lat = sh + 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = $urandom_range(0, 255);
        b        = $urandom_range(0, 255);
    endtask

    // Wait for the result, check it, stall for 'stall' cycles, then optionally handshake.
    task automatic expect_result(input logic [7:0] av, input logic [7:0] bv, input int stall,
                                 input bit handshake);
        int bn, sh, sd, d0, lat;
        int n = 0;
        model(bv, bn, sh, sd, d0, lat);
        out_ready = 1'b0;
        while (!out_valid && n < 20) begin
            check("in_ready_busy", in_ready, 0);
            step();
            n++;
        end
        check("latency", n, lat);
        for (int i = 0; i <= stall; i++) begin
            check("out_valid", out_valid, 1);
            check("a_q", a_q, av);
            check("b_n", b_n, bn);
            check("shamt", shamt, sh);
            check("seed", seed, sd);
            check("div0", div0, d0);
            if (i < stall) begin
                in_valid = $urandom_range(0, 1);
                step();
            end
        end
        in_valid = 1'b0;
        if (handshake) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("out_valid_drop", out_valid, 0);
            check("in_ready_after_hs", in_ready, 1);
            check("b_n_kept", b_n, bn);
            check("seed_kept", seed, sd);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fields", {a_q, b_n, seed, shamt, div0}, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Reset while shifting b = 0x01.
        send(8'h55, 8'h01);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("midrst_out_valid", out_valid, 0);
            step();
            check("midrst_in_ready", in_ready, 0);
            check("midrst_fields", {a_q, b_n, seed, shamt, div0}, 0);
        end
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_valid", out_valid, 0);
            step();
        end

        send(8'h64, 8'h80);
        expect_result(8'h64, 8'h80, 0, 1);
        send(8'hFF, 8'h01);
        expect_result(8'hFF, 8'h01, 0, 1);
        send(8'h12, 8'h0B);
        expect_result(8'h12, 8'h0B, 0, 1);
        send(8'h2A, 8'h00);
        expect_result(8'h2A, 8'h00, 2, 1);

        // Backpressure, then back-to-back accept right after the handshake.
        send(8'h77, 8'hF0);
        expect_result(8'h77, 8'hF0, 10, 0);
        a         = 8'h9C;
        b         = 8'h03;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_in_ready", in_ready, 1);
        check("b2b_out_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("b2b_accepted", in_ready, 0);
        expect_result(8'h9C, 8'h03, 0, 1);

        for (int t = 0; t < 60; t++) begin
            logic [7:0] ra, rb;
            ra = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0:       rb = 8'd0;
                1:       rb = 8'd1 << $urandom_range(0, 7);
                default: rb = $urandom_range(0, 255);
            endcase
            send(ra, rb);
            expect_result(ra, rb, $urandom_range(0, 3), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
